cmos_rgb565_capture: RTL and testbench

- Upstream stage of the SDRAM/VGA frame-buffer top, running in the camera pixel-clock domain.
- Samples the OV7670 8-bit DVP bus (vsync, href, data) and pairs bytes into RGB565 words.
- Discards the first FRAME_SKIP frames after sensor configuration completes, then drives the frame-buffer write port (write clock = clk, fifo write enable, 16-bit data, frame_valid).
- Produces frame-aligned output: writes always start on a vsync boundary.

---
 rtl/cmos_rgb565_capture.sv | 188 ++++++++++++++++++
 tb/tb_cmos_rgb565_capture.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmos_rgb565_capture.sv
// cmos_rgb565_capture: OV7670 DVP byte-pair capture into RGB565 words.
// Drops the first FRAME_SKIP frames after sensor init, then emits
// frame-aligned pixel strobes for the frame-buffer write port.
// Optional macro CMOS_FRAME_ERR_EN adds sticky line_err / frame_err outputs.
module cmos_rgb565_capture #(
    parameter int FRAME_SKIP = 10,
    parameter int H_DISP     = 640,
    parameter int V_DISP     = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmos_init_done,
    input  logic        cmos_vsync,
    input  logic        cmos_href,
    input  logic [7:0]  cmos_data,
    output logic        cmos_frame_clken,
    output logic [15:0] cmos_frame_data,
    output logic        cmos_frame_vsync,
    output logic        frame_valid,
    output logic [7:0]  frame_cnt
`ifdef CMOS_FRAME_ERR_EN
    ,
    output logic        line_err,
    output logic        frame_err
`endif
);

    localparam bit PARAMS_OK = (FRAME_SKIP >= 1) && (FRAME_SKIP <= 255) &&
                               (H_DISP >= 1) && (H_DISP < 2048) &&
                               (V_DISP >= 1) && (V_DISP < 1024);
    localparam logic [7:0] SKIP_N = 8'(FRAME_SKIP);

    generate
        if (!PARAMS_OK) begin : g_param_check
            $error("cmos_rgb565_capture: parameter out of range");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_WAIT_INIT,
        ST_SKIP,
        ST_CAPTURE
    } state_t;

    state_t      state, state_nxt;
    logic        s1_vsync, s1_vsync_d, s1_href;
    logic [7:0]  s1_data;
    logic        byte_flag;
    logic [7:0]  high_byte;
    logic        vs_rise;
    logic [7:0]  frame_cnt_inc;
    logic [7:0]  frame_cnt_nxt;
    logic        frame_valid_nxt;
    logic        clken_nxt;

    assign vs_rise          = s1_vsync & ~s1_vsync_d;
    assign frame_cnt_inc    = frame_cnt + 8'd1;
    assign cmos_frame_vsync = s1_vsync_d & frame_valid;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_WAIT_INIT;
        else        state <= state_nxt;
    end

    // Next-state logic; losing init_done always returns to ST_WAIT_INIT
    always_comb begin
        state_nxt = state;
        if (!cmos_init_done) begin
            state_nxt = ST_WAIT_INIT;
        end else begin
            case (state)
                ST_WAIT_INIT: state_nxt = ST_SKIP;
                ST_SKIP:      if (vs_rise && frame_cnt_inc == SKIP_N) state_nxt = ST_CAPTURE;
                ST_CAPTURE:   state_nxt = ST_CAPTURE;
                default:      state_nxt = ST_WAIT_INIT;
            endcase
        end
    end

    // Output logic: frame counter / valid updates and pixel strobe request
    always_comb begin
        frame_cnt_nxt   = frame_cnt;
        frame_valid_nxt = frame_valid;
        clken_nxt       = 1'b0;
        if (!cmos_init_done) begin
            frame_cnt_nxt   = '0;
            frame_valid_nxt = 1'b0;
        end else begin
            case (state)
                ST_WAIT_INIT: begin
                    frame_cnt_nxt   = '0;
                    frame_valid_nxt = 1'b0;
                end
                ST_SKIP: begin
                    if (vs_rise) begin
                        frame_cnt_nxt = frame_cnt_inc;
                        if (frame_cnt_inc == SKIP_N) frame_valid_nxt = 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    frame_cnt_nxt   = SKIP_N;
                    frame_valid_nxt = 1'b1;
                    clken_nxt       = s1_href & byte_flag;
                end
                default: begin
                    frame_cnt_nxt   = '0;
                    frame_valid_nxt = 1'b0;
                end
            endcase
        end
    end

    // Input registers, byte pairing and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vsync         <= 1'b0;
            s1_vsync_d       <= 1'b0;
            s1_href          <= 1'b0;
            s1_data          <= '0;
            byte_flag        <= 1'b0;
            high_byte        <= '0;
            cmos_frame_clken <= 1'b0;
            cmos_frame_data  <= '0;
            frame_cnt        <= '0;
            frame_valid      <= 1'b0;
        end else begin
            s1_vsync    <= cmos_vsync;
            s1_vsync_d  <= s1_vsync;
            s1_href     <= cmos_href;
            s1_data     <= cmos_data;
            frame_cnt   <= frame_cnt_nxt;
            frame_valid <= frame_valid_nxt;
            if (!cmos_init_done || !s1_href) byte_flag <= 1'b0;
            else                             byte_flag <= ~byte_flag;
            if (s1_href && !byte_flag) high_byte <= s1_data;
            cmos_frame_clken <= clken_nxt;
            if (clken_nxt) cmos_frame_data <= {high_byte, s1_data};
        end
    end

`ifdef CMOS_FRAME_ERR_EN
    logic        s1_href_d;
    logic        href_fall;
    logic [10:0] pix_cnt;
    logic [9:0]  line_cnt;
    logic        cap_armed;

    assign href_fall = s1_href_d & ~s1_href;

    // Saturating pixel/line counters; vs_rise has priority over href activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_href_d <= 1'b0;
            pix_cnt   <= '0;
            line_cnt  <= '0;
        end else begin
            s1_href_d <= s1_href;
            if (vs_rise || href_fall)                     pix_cnt <= '0;
            else if (s1_href && byte_flag && pix_cnt != '1) pix_cnt <= pix_cnt + 11'd1;
            if (vs_rise)                                  line_cnt <= '0;
            else if (href_fall && line_cnt != '1)         line_cnt <= line_cnt + 10'd1;
        end
    end

    // Sticky geometry errors, checked only while capturing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            cap_armed <= 1'b0;
        end else if (state == ST_WAIT_INIT) begin
            line_err  <= 1'b0;
            frame_err <= 1'b0;
            cap_armed <= 1'b0;
        end else if (state == ST_CAPTURE) begin
            if (href_fall && (pix_cnt != 11'(H_DISP) || byte_flag)) line_err <= 1'b1;
            if (vs_rise) begin
                cap_armed <= 1'b1;
                if (cap_armed && line_cnt != 10'(V_DISP)) frame_err <= 1'b1;
            end
        end else begin
            cap_armed <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_cmos_rgb565_capture.sv
// Scoreboard bench for cmos_rgb565_capture: stimulus pushes expected pixels
// (value and strobe cycle) into a queue, a monitor pops on every strobe.
module tb_cmos_rgb565_capture;

    localparam int FS = 3;
    localparam int HD = 8;
    localparam int VD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmos_init_done = 1'b0;
    logic        cmos_vsync = 1'b0;
    logic        cmos_href = 1'b0;
    logic [7:0]  cmos_data = '0;
    logic        cmos_frame_clken;
    logic [15:0] cmos_frame_data;
    logic        cmos_frame_vsync;
    logic        frame_valid;
    logic [7:0]  frame_cnt;
`ifdef CMOS_FRAME_ERR_EN
    logic        line_err;
    logic        frame_err;
`endif

    cmos_rgb565_capture #(
        .FRAME_SKIP(FS),
        .H_DISP    (HD),
        .V_DISP    (VD)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cmos_init_done  (cmos_init_done),
        .cmos_vsync      (cmos_vsync),
        .cmos_href       (cmos_href),
        .cmos_data       (cmos_data),
        .cmos_frame_clken(cmos_frame_clken),
        .cmos_frame_data (cmos_frame_data),
        .cmos_frame_vsync(cmos_frame_vsync),
        .frame_valid     (frame_valid),
        .frame_cnt       (frame_cnt)
`ifdef CMOS_FRAME_ERR_EN
        ,
        .line_err        (line_err),
        .frame_err       (frame_err)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] d;
        int          c;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fixed_q[$];
    int compared   = 0;
    int mismatched = 0;
    int strobes    = 0;

    // Reference model state: sensor init seen, vsyncs counted since init
    bit init_m = 1'b0;
    int mcnt   = 0;

    function automatic bit capturing();
        return init_m && (mcnt >= FS);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one href run of n bytes; every completed byte pair is a pixel
    task automatic send_line(input int n);
        logic [7:0] hi, b;
        hi = '0;
        for (int i = 0; i < n; i++) begin
            if (fixed_q.size() > 0) b = fixed_q.pop_front();
            else                    b = 8'($urandom);
            cmos_href = 1'b1;
            cmos_data = b;
            if (i % 2 == 0) hi = b;
            else if (capturing()) exp_q.push_back('{d: {hi, b}, c: cyc + 2});
            tick();
        end
        cmos_href = 1'b0;
        cmos_data = 8'($urandom);
        repeat (4) tick();
    endtask

    // Vsync pulse with frame counter / valid / aligned vsync checks
    task automatic vsync_pulse();
        cmos_vsync = 1'b1;
        tick();
        check("frame_cnt_before_rise", frame_cnt, mcnt);
        tick();
        if (init_m) mcnt = (mcnt < FS) ? mcnt + 1 : FS;
        check("frame_cnt_after_rise", frame_cnt, mcnt);
        check("frame_valid_after_rise", frame_valid, (mcnt >= FS));
        check("frame_vsync_after_rise", cmos_frame_vsync, (mcnt >= FS));
        tick();
        cmos_vsync = 1'b0;
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_clken"}, cmos_frame_clken, 0);
        check({tag, "_data"}, cmos_frame_data, 0);
        check({tag, "_fvsync"}, cmos_frame_vsync, 0);
        check({tag, "_fvalid"}, frame_valid, 0);
        check({tag, "_fcnt"}, frame_cnt, 0);
    endtask

    // Monitor: every strobe must match the oldest expected pixel and its cycle
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (cmos_frame_clken) begin
                strobes++;
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL unexpected_clken: got data %0h expected no strobe (cycle %0d)",
                             cmos_frame_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (cmos_frame_data !== e.d) begin
                        mismatched++;
                        $display("FAIL pixel_data: got %0h expected %0h (cycle %0d)",
                                 cmos_frame_data, e.d, cyc);
                    end
                    compared++;
                    if (cyc != e.c) begin
                        mismatched++;
                        $display("FAIL pixel_latency: got cycle %0d expected cycle %0d", cyc, e.c);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        repeat (3) tick();
        check_all_zero("reset");
        rst_n = 1'b1;
        repeat (2) tick();

        // Activity before init and before the skip count: no strobes allowed
        send_line(4);
        cmos_init_done = 1'b1;
        init_m = 1'b1;
        mcnt = 0;
        repeat (3) tick();
        send_line(4);
        for (int k = 0; k < FS; k++) begin
            vsync_pulse();
            if (k < FS - 1) send_line(4);
        end

        // Pure red and pure green pixels
        fixed_q = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        send_line(4);
        // Odd trailing byte is dropped, the next line starts fresh
        fixed_q = '{8'h12, 8'h34, 8'h56};
        send_line(3);
`ifdef CMOS_FRAME_ERR_EN
        check("line_err_odd", line_err, 1);
`endif
        fixed_q = '{8'hAB, 8'hCD};
        send_line(2);

        // Full frame at bench geometry
        vsync_pulse();
        s0 = strobes;
        for (int l = 0; l < VD; l++) send_line(2 * HD);
        check("frame_strobe_count", strobes - s0, HD * VD);
        vsync_pulse();
        for (int l = 0; l < 6; l++) send_line($urandom_range(1, 12));

        // Drop init_done mid-line: pair in flight is discarded
        cmos_href = 1'b1;
        cmos_data = 8'h11; tick();
        cmos_data = 8'h22;
        if (capturing()) exp_q.push_back('{d: 16'h1122, c: cyc + 2});
        tick();
        cmos_data = 8'h33; tick();
        cmos_data = 8'h44;
        cmos_init_done = 1'b0;
        init_m = 1'b0;
        mcnt = 0;
        tick();
        check("drop_fvalid", frame_valid, 0);
        check("drop_fcnt", frame_cnt, 0);
        cmos_data = 8'h55; tick();
        cmos_data = 8'h66; tick();
        cmos_href = 1'b0;
        repeat (4) tick();
        check("drop_fvsync", cmos_frame_vsync, 0);

        // Re-init needs FRAME_SKIP fresh vsyncs
        cmos_init_done = 1'b1;
        init_m = 1'b1;
        repeat (3) tick();
        send_line(4);
        for (int k = 0; k < FS; k++) begin
            vsync_pulse();
            send_line(6);
        end

        // Asynchronous reset between clock edges mid-line
        cmos_href = 1'b1;
        cmos_data = 8'hC3; tick();
        cmos_data = 8'h3C;
        exp_q.push_back('{d: 16'hC33C, c: cyc + 2});
        tick();
        cmos_data = 8'h99; tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        cmos_href = 1'b0;
        mcnt = 0;
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        send_line(4);
        for (int k = 0; k < FS; k++) begin
            vsync_pulse();
            send_line(8);
        end

        repeat (10) tick();
        check("scoreboard_drain", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
